// File: rtl/direction_tracker_if.sv
// Interface between the localiser/classifier front end and the direction tracker.
// Carries the per-frame estimate, the classifier hit and the confirmed heading outputs.
interface direction_tracker_if;
    logic        est_valid;
    logic [3:0]  est_bin;
    logic [15:0] est_mag;
    logic        cat_detect;
    logic [3:0]  bin;
    logic        recognised;
    logic [1:0]  state_out;

    modport master (
        output est_valid, est_bin, est_mag, cat_detect,
        input  bin, recognised, state_out
    );

    modport slave (
        input  est_valid, est_bin, est_mag, cat_detect,
        output bin, recognised, state_out
    );
endinterface

// File: rtl/direction_tracker.sv
// Confirms a stable direction-of-arrival heading during a keyword recognition window
// using magnitude gating, circular neighbour voting and hold/gap timers.
module direction_tracker #(
    parameter logic [15:0] MAG_THRESH     = 16'd1024,
    parameter int unsigned CONFIRM_COUNT  = 3,
    parameter int unsigned HOLD_CYCLES    = 98_304_000,
    parameter int unsigned TIMEOUT_CYCLES = 19_660_800
) (
    input logic             clk_in,
    input logic             rst_in,
    direction_tracker_if.slave bus
);

    localparam int unsigned CntW  = $clog2(CONFIRM_COUNT + 1);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned GapW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CntW-1:0]  CntMax    = CntW'(CONFIRM_COUNT);
    localparam logic [HoldW-1:0] HoldLoad  = HoldW'(HOLD_CYCLES);
    localparam logic [GapW-1:0]  GapMax    = GapW'(TIMEOUT_CYCLES);
    localparam logic [GapW-1:0]  GapLast   = GapW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAcquire = 2'b01,
        StTrack   = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [3:0]       bin_q, bin_d;
    logic             rec_q, rec_d;

    logic             qual;
    logic [3:0]       diff;
    logic             nbr;
    logic [CntW-1:0]  vote_cnt;
    logic             hold_exp;
    logic             gap_exp;

    always_comb begin
        qual = bus.est_valid && (bus.est_mag >= MAG_THRESH);
        diff = bus.est_bin - cand_q;
        nbr  = (diff == 4'd0) || (diff == 4'd1) || (diff == 4'd15);
        if ((count_q == '0) || nbr) begin
            vote_cnt = (count_q < CntMax) ? count_q + CntW'(1) : CntMax;
        end else begin
            vote_cnt = CntW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        count_d  = count_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        bin_d    = bin_q;
        hold_exp = 1'b0;
        gap_exp  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cat_detect) begin
                    state_d = StAcquire;
                    hold_d  = HoldLoad;
                    gap_d   = '0;
                    count_d = '0;
                end
            end
            StAcquire, StTrack: begin
                hold_d = (hold_q != '0) ? hold_q - HoldW'(1) : '0;
                gap_d  = (gap_q < GapMax) ? gap_q + GapW'(1) : gap_q;
                if (bus.cat_detect) begin
                    hold_d = HoldLoad;
                end
                if (qual) begin
                    cand_d  = bus.est_bin;
                    count_d = vote_cnt;
                    gap_d   = '0;
                    if (vote_cnt == CntMax) begin
                        bin_d   = bus.est_bin;
                        state_d = StTrack;
                    end
                end
                // Reload beats hold expiry; a qualifying estimate beats gap timeout.
                hold_exp = !bus.cat_detect && (hold_q <= HoldW'(1));
                gap_exp  = !qual && (gap_q >= GapLast);
                if (hold_exp || gap_exp) begin
                    state_d = StIdle;
                    count_d = '0;
                    bin_d   = bin_q;
                    hold_d  = '0;
                    gap_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        rec_d = (state_d == StTrack);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= StIdle;
            cand_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            bin_q   <= '0;
            rec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            bin_q   <= bin_d;
            rec_q   <= rec_d;
        end
    end

    assign bus.bin        = bin_q;
    assign bus.recognised = rec_q;
    assign bus.state_out  = state_q;

endmodule

// File: tb/tb_direction_tracker.sv
// Directed bench for direction_tracker with shortened hold/timeout windows.
module tb_direction_tracker;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    direction_tracker_if dt_if ();

    direction_tracker #(
        .MAG_THRESH    (16'd1024),
        .CONFIRM_COUNT (3),
        .HOLD_CYCLES   (200),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (dt_if.slave)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input int b, input int r, input int s);
        check({tag, "_bin"}, 32'(dt_if.bin), 32'(b));
        check({tag, "_rec"}, 32'(dt_if.recognised), 32'(r));
        check({tag, "_st"}, 32'(dt_if.state_out), 32'(s));
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input int b, input int m);
        dt_if.est_valid = 1'b1;
        dt_if.est_bin   = 4'(b);
        dt_if.est_mag   = 16'(m);
        tick();
        dt_if.est_valid = 1'b0;
    endtask

    task automatic cat();
        dt_if.cat_detect = 1'b1;
        tick();
        dt_if.cat_detect = 1'b0;
    endtask

    initial begin
        dt_if.est_valid  = 1'b0;
        dt_if.est_bin    = 4'd0;
        dt_if.est_mag    = 16'd0;
        dt_if.cat_detect = 1'b0;

        // Reset held while estimates toggle
        for (int i = 0; i < 4; i++) begin
            strobe(i + 3, 3000);
            outs("rst", 0, 0, 0);
        end
        rst_in = 1'b1;
        // IDLE ignores qualifying estimates
        strobe(5, 2000);
        strobe(5, 2000);
        strobe(5, 2000);
        outs("idle_ign", 0, 0, 0);

        // Confirm 5,5,6
        cat();
        outs("acq_enter", 0, 0, 1);
        strobe(5, 2000);
        strobe(5, 2000);
        outs("acq_two", 0, 0, 1);
        strobe(6, 2000);
        outs("confirm6", 6, 1, 2);
        // Drift follows, non-neighbour holds until re-confirmed
        strobe(7, 2000);
        outs("drift7", 7, 1, 2);
        strobe(12, 2000);
        outs("jump12_a", 7, 1, 2);
        strobe(12, 2000);
        outs("jump12_b", 7, 1, 2);
        strobe(12, 2000);
        outs("jump12_c", 12, 1, 2);

        // Low-magnitude strobes do not refresh gap timer
        for (int i = 0; i < 49; i++) strobe(3, 500);
        outs("gap_49", 12, 1, 2);
        tick();
        outs("gap_50", 12, 0, 0);

        // Wrap-around neighbours
        cat();
        strobe(15, 2000);
        strobe(0, 2000);
        strobe(1, 2000);
        outs("wrap", 1, 1, 2);
        idle(50);
        outs("wrap_to", 1, 0, 0);

        // Scattered bins never confirm
        cat();
        strobe(4, 2000);
        strobe(9, 2000);
        strobe(4, 2000);
        outs("scatter", 1, 0, 1);
        idle(50);
        outs("scatter_to", 1, 0, 0);

        // Hold expiry 200 cycles after cat_detect
        cat();
        for (int i = 0; i < 19; i++) begin
            strobe(8, 2000);
            idle(9);
        end
        strobe(8, 2000);
        idle(8);
        outs("hold_199", 8, 1, 2);
        tick();
        outs("hold_200", 8, 0, 0);

        // Second cat_detect at cycle 150 extends window to 350
        cat();
        for (int i = 0; i < 14; i++) begin
            strobe(10, 2000);
            idle(9);
        end
        strobe(10, 2000);
        idle(8);
        cat();
        for (int i = 0; i < 19; i++) begin
            strobe(10, 2000);
            idle(9);
        end
        outs("ext_340", 10, 1, 2);
        strobe(10, 2000);
        idle(8);
        outs("ext_349", 10, 1, 2);
        tick();
        outs("ext_350", 10, 0, 0);

        // Asynchronous reset mid-TRACK
        cat();
        strobe(2, 2000);
        strobe(2, 2000);
        strobe(2, 2000);
        outs("pre_rst", 2, 1, 2);
        rst_in = 1'b0;
        #1;
        outs("async_rst", 0, 0, 0);
        #1;
        rst_in = 1'b1;
        strobe(2, 2000);
        strobe(2, 2000);
        strobe(2, 2000);
        outs("post_rst", 0, 0, 0);
        cat();
        outs("post_cat", 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
